cache_fill_fsm: RTL and testbench

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

---
 rtl/cache_fill_fsm_pkg.sv | 34 +++
 rtl/cache_fill_fsm_decoder.sv | 16 +
 rtl/cache_fill_fsm_dff.sv | 18 +
 rtl/cache_fill_fsm.sv | 136 +++++++++++++
 tb/tb_cache_fill_fsm.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// cache_fill_fsm_pkg: shared cache constants, state encodings and metadata helper
// for the block-fill controller and its helper cells.
package cache_fill_fsm_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int TAG_W           = 5;
  localparam int INDEX_W         = 7;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int META_W          = 8;
  localparam int NUM_BLOCKS      = 1 << INDEX_W;
  localparam int CNT_W           = $clog2(WORDS_PER_BLOCK);

  // Request counter runs one past the last word so "all reads issued" is a plain compare.
  localparam logic [CNT_W:0]   REQ_LIMIT = (CNT_W + 1)'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

  // Fill controller state encodings; IDLE must stay all-zero so register reset lands there.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_TAGWR = 2'd2;

  // Line identity of a miss: the upper address bits above the 16-byte block offset.
  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
  } line_id_t;

  // Metadata byte written on fill completion: valid bit set, two spare bits clear, tag below.
  function automatic logic [META_W-1:0] make_meta(input logic [TAG_W-1:0] tag);
    return {1'b1, 2'b00, tag};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_decoder.sv
// decoder_7_128: one-hot block select for the data and metadata arrays.
module decoder_7_128
  import cache_fill_fsm_pkg::*;
(
  input  logic                  en,
  input  logic [INDEX_W-1:0]    sel,
  output logic [NUM_BLOCKS-1:0] onehot
);

  // Raise exactly the selected block line while enabled, nothing otherwise.
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/cache_fill_fsm_dff.sv
// dff: codebase register cell, synchronous active-high reset to a fixed value.
module dff #(
  parameter int              WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on every rising edge; reset forces the fixed reset value.
  always_ff @(posedge clk) begin
    if (rst) q <= RESET_VALUE;
    else     q <= d;
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: on a cache miss, streams the 8-word block from main memory into
// the data array, then writes the line's metadata byte and releases the pipeline.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         miss_detected,
  input  logic [15:0]  miss_address,
  input  logic [15:0]  memory_data,
  input  logic         memory_data_valid,
  output logic         fsm_busy,
  output logic         memory_read,
  output logic [15:0]  memory_address,
  output logic [127:0] block_enable,
  output logic [7:0]   word_enable,
  output logic         write_data_array,
  output logic [15:0]  fill_data,
  output logic         write_tag_array,
  output logic [7:0]   meta_data_out
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W:0]   req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0] recv_cnt_q, recv_cnt_d;
  line_id_t         line_q, line_d;
  logic             block_sel_en;
  logic             offset_bits_unused;

  // The byte offset inside the block never matters: fills always start at word 0.
  assign offset_bits_unused = ^miss_address[3:0];

  // Returned words go straight to the data array; only the strobes are gated.
  assign fill_data = memory_data;

  dff #(.WIDTH(2), .RESET_VALUE(ST_IDLE)) u_state_reg (
    .clk (clk),
    .rst (rst),
    .d   (state_d),
    .q   (state_q)
  );

  dff #(.WIDTH(CNT_W + 1)) u_req_cnt_reg (
    .clk (clk),
    .rst (rst),
    .d   (req_cnt_d),
    .q   (req_cnt_q)
  );

  dff #(.WIDTH(CNT_W)) u_recv_cnt_reg (
    .clk (clk),
    .rst (rst),
    .d   (recv_cnt_d),
    .q   (recv_cnt_q)
  );

  dff #(.WIDTH(TAG_W + INDEX_W)) u_line_reg (
    .clk (clk),
    .rst (rst),
    .d   (line_d),
    .q   (line_q)
  );

  // Next-state logic: latch the line on a miss, pace requests, count returns, finish with the tag write.
  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    recv_cnt_d = recv_cnt_q;
    line_d     = line_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_detected) begin
          state_d    = ST_FILL;
          line_d     = miss_address[15:4];
          req_cnt_d  = '0;
          recv_cnt_d = '0;
        end
      end
      ST_FILL: begin
        if (req_cnt_q < REQ_LIMIT) req_cnt_d = req_cnt_q + 1'b1;
        if (memory_data_valid) begin
          recv_cnt_d = recv_cnt_q + 1'b1;
          if (recv_cnt_q == LAST_WORD) state_d = ST_TAGWR;
        end
      end
      ST_TAGWR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: everything is a function of the registered state except the word strobe,
  // which follows memory_data_valid so any memory latency is tolerated.
  always_comb begin
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    memory_address   = '0;
    word_enable      = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    meta_data_out    = '0;
    block_sel_en     = 1'b0;
    case (state_q)
      ST_FILL: begin
        fsm_busy     = 1'b1;
        block_sel_en = 1'b1;
        if (req_cnt_q < REQ_LIMIT) begin
          memory_read    = 1'b1;
          memory_address = {line_q.tag, line_q.index, req_cnt_q[CNT_W-1:0], 1'b0};
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_enable      = 8'b1 << recv_cnt_q;
        end
      end
      ST_TAGWR: begin
        fsm_busy        = 1'b1;
        block_sel_en    = 1'b1;
        write_tag_array = 1'b1;
        meta_data_out   = make_meta(line_q.tag);
      end
      default: begin
      end
    endcase
  end

  decoder_7_128 u_block_decoder (
    .en     (block_sel_en),
    .sel    (line_q.index),
    .onehot (block_enable)
  );

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: randomized memory-latency bench with a scoreboard; expected reads,
// word writes and tag writes are queued when a miss is issued and popped by a monitor.
module tb_cache_fill_fsm;

  typedef struct {
    logic [7:0]   we;
    logic [127:0] be;
    logic [15:0]  data;
  } wr_exp_t;

  typedef struct {
    logic [7:0]   meta;
    logic [127:0] be;
  } tag_exp_t;

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_detected;
  logic [15:0]  miss_address;
  logic [15:0]  memory_data;
  logic         memory_data_valid;
  logic         fsm_busy;
  logic         memory_read;
  logic [15:0]  memory_address;
  logic [127:0] block_enable;
  logic [7:0]   word_enable;
  logic         write_data_array;
  logic [15:0]  fill_data;
  logic         write_tag_array;
  logic [7:0]   meta_data_out;
  logic [163:0] all_out;

  logic [15:0] exp_read[$];
  wr_exp_t     exp_write[$];
  tag_exp_t    exp_tag[$];
  pend_t       pend[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int miss_cyc = 0;
  int first_read_cyc = -1;
  int first_write_cyc = -1;
  int last_write_cyc = -1;
  int tag_cyc = -1;
  int write_count = 0;
  int read_count = 0;
  logic [15:0] last_read_addr = '0;

  int lat = 4;
  int max_gap = 1;
  bit pattern_mode = 1'b0;
  int pat_idx = 0;
  int last_ret = 0;
  int gap_pat[3] = '{1, 3, 7};
  bit stray_pending = 1'b0;
  logic [15:0] salt = '0;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .block_enable      (block_enable),
    .word_enable       (word_enable),
    .write_data_array  (write_data_array),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .meta_data_out     (meta_data_out)
  );

  assign all_out = {fsm_busy, memory_read, memory_address, block_enable, word_enable,
                    write_data_array, write_tag_array, meta_data_out};

  always #5 clk = ~clk;

  // Cycle index: value seen between two rising edges.
  always @(posedge clk) cyc <= cyc + 1;

  // Content the modelled memory holds at a word address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ salt;
  endfunction

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Issue a miss and queue everything the fill must produce, derived from address arithmetic.
  task automatic applyStimulus(input logic [15:0] addr, input bit hold);
    logic [15:0]  base;
    logic [127:0] be;
    wr_exp_t      w;
    tag_exp_t     t;
    @(negedge clk);
    base = addr & 16'hFFF0;
    be   = 128'(1) << addr[10:4];
    for (int i = 0; i < 8; i++) begin
      exp_read.push_back(base + 16'(2 * i));
      w.we   = 8'(1 << i);
      w.be   = be;
      w.data = mem_word(base + 16'(2 * i));
      exp_write.push_back(w);
    end
    t.meta = 8'h80 | {3'b000, addr[15:11]};
    t.be   = be;
    exp_tag.push_back(t);
    first_read_cyc  = -1;
    first_write_cyc = -1;
    last_write_cyc  = -1;
    tag_cyc         = -1;
    write_count     = 0;
    read_count      = 0;
    pat_idx         = 0;
    miss_cyc        = cyc;
    miss_address    = addr;
    miss_detected   = 1'b1;
    if (!hold) begin
      @(negedge clk);
      miss_detected = 1'b0;
      miss_address  = 16'($urandom);
    end
  endtask

  task automatic waitTag(input string name);
    int n;
    n = 0;
    while (tag_cyc < 0 && n < 300) begin
      @(negedge clk);
      #3;
      n++;
    end
    checks++;
    if (tag_cyc < 0) begin
      failures++;
      $display("[TB] FAIL %s_tag_timeout actual=none required=tag_write", name);
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((pend.size() > 0 || fsm_busy) && n < 300) begin
      @(negedge clk);
      #3;
      n++;
    end
    checks++;
    if (pend.size() > 0 || fsm_busy) begin
      failures++;
      $display("[TB] FAIL %s_drain_timeout actual=busy required=idle", name);
    end
    repeat (2) @(negedge clk);
    #3;
  endtask

  task automatic finishFill(input string name);
    waitTag(name);
    @(negedge clk);
    miss_detected = 1'b0;
    #3;
    checkOutput({name, "_busy_after_tag"}, 192'(fsm_busy), 192'(0));
    waitDrain(name);
  endtask

  // Memory model: in-order returns, each at least lat cycles after its request and
  // spaced from the previous return by a random or patterned gap.
  initial begin
    pend_t p;
    int    sp;
    memory_data_valid = 1'b0;
    memory_data       = '0;
    forever begin
      @(negedge clk);
      if (memory_read === 1'b1) begin
        sp = pattern_mode ? gap_pat[pat_idx % 3] : int'($urandom_range(max_gap, 1));
        pat_idx++;
        p.addr = memory_address;
        p.due  = cyc + lat;
        if (p.due < last_ret + sp) p.due = last_ret + sp;
        last_ret = p.due;
        pend.push_back(p);
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        memory_data_valid = 1'b1;
        memory_data       = mem_word(p.addr);
      end else if (stray_pending) begin
        stray_pending     = 1'b0;
        memory_data_valid = 1'b1;
        memory_data       = 16'($urandom);
      end else begin
        memory_data_valid = 1'b0;
        memory_data       = 16'($urandom);
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes, and checks quiet outputs otherwise.
  initial begin
    wr_exp_t     w;
    tag_exp_t    t;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      #2;
      if (cyc < 1) continue;
      if (!fsm_busy) checkOutput("idle_outputs_zero", 192'(all_out), 192'(0));
      if (!write_data_array) checkOutput("word_enable_quiet", 192'(word_enable), 192'(0));
      if (!write_tag_array) checkOutput("meta_quiet", 192'(meta_data_out), 192'(0));
      if (memory_read) begin
        read_count++;
        last_read_addr = memory_address;
        if (first_read_cyc < 0) first_read_cyc = cyc;
        if (exp_read.size() == 0) checkOutput("spurious_read", 192'(memory_read), 192'(0));
        else begin
          a = exp_read.pop_front();
          checkOutput("read_address", 192'(memory_address), 192'(a));
        end
      end
      if (write_data_array) begin
        write_count++;
        if (first_write_cyc < 0) first_write_cyc = cyc;
        last_write_cyc = cyc;
        if (exp_write.size() == 0) checkOutput("spurious_write", 192'(write_data_array), 192'(0));
        else begin
          w = exp_write.pop_front();
          checkOutput("word_enable", 192'(word_enable), 192'(w.we));
          checkOutput("write_block_enable", 192'(block_enable), 192'(w.be));
          checkOutput("fill_data", 192'(fill_data), 192'(w.data));
        end
      end
      if (write_tag_array) begin
        tag_cyc = cyc;
        if (exp_tag.size() == 0) checkOutput("spurious_tag_write", 192'(write_tag_array), 192'(0));
        else begin
          t = exp_tag.pop_front();
          checkOutput("meta_data_out", 192'(meta_data_out), 192'(t.meta));
          checkOutput("tag_block_enable", 192'(block_enable), 192'(t.be));
          checkOutput("tag_one_after_last_word", 192'(cyc - last_write_cyc), 192'(1));
          checkOutput("words_left_at_tag", 192'(exp_write.size()), 192'(0));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t1;
    int n;
    int wc;
    salt          = 16'($urandom);
    rst           = 1'b1;
    miss_detected = 1'b0;
    miss_address  = '0;
    repeat (3) @(negedge clk);
    #3;
    checkOutput("reset_outputs", 192'(all_out), 192'(0));

    // Reset wins over a miss in the same cycle.
    @(negedge clk);
    miss_detected = 1'b1;
    miss_address  = 16'h1A36;
    @(negedge clk);
    rst           = 1'b0;
    miss_detected = 1'b0;
    #3;
    checkOutput("rst_beats_miss_busy", 192'(fsm_busy), 192'(0));
    repeat (3) @(negedge clk);
    #3;
    checkOutput("rst_beats_miss_no_reads", 192'(read_count), 192'(0));

    // Basic fill with a fixed latency-4 memory.
    $display("[TB] basic fill at 0x1A36");
    lat = 4; max_gap = 1; pattern_mode = 1'b0;
    applyStimulus(16'h1A36, 1'b0);
    waitTag("basic");
    checkOutput("basic_first_read_cycle", 192'(first_read_cyc - miss_cyc), 192'(1));
    checkOutput("basic_first_write_cycle", 192'(first_write_cyc - miss_cyc), 192'(5));
    checkOutput("basic_last_write_cycle", 192'(last_write_cyc - miss_cyc), 192'(12));
    checkOutput("basic_tag_cycle", 192'(tag_cyc - miss_cyc), 192'(13));
    @(negedge clk);
    #3;
    checkOutput("basic_busy_low_cycle14", 192'(fsm_busy), 192'(0));
    waitDrain("basic");

    // Top of memory.
    $display("[TB] top-of-memory fill at 0xFFFF");
    lat = int'($urandom_range(6, 1)); max_gap = 2;
    applyStimulus(16'hFFFF, 1'b0);
    finishFill("top");
    checkOutput("top_last_read_address", 192'(last_read_addr), 192'(16'hFFFE));
    checkOutput("top_read_count", 192'(read_count), 192'(8));

    // Miss held high through the whole fill, then a stray valid in IDLE.
    $display("[TB] busy filtering");
    lat = 3; max_gap = 2;
    applyStimulus(16'h5A5C, 1'b1);
    finishFill("busy_filter");
    stray_pending = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    checkOutput("busy_filter_one_fill_reads", 192'(read_count), 192'(8));
    checkOutput("stray_valid_no_write", 192'(write_count), 192'(8));

    // Irregular return spacing 1, 3, 7.
    $display("[TB] irregular latency");
    lat = 1; pattern_mode = 1'b1;
    applyStimulus(16'h2468, 1'b0);
    finishFill("irregular");
    checkOutput("irregular_write_count", 192'(write_count), 192'(8));
    pattern_mode = 1'b0;

    // Reset after the third word; the fill must be abandoned without a tag write.
    $display("[TB] reset mid-fill");
    lat = 4; max_gap = 1;
    applyStimulus(16'h7B10, 1'b0);
    n = 0;
    while (write_count < 3 && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_read.delete();
    exp_write.delete();
    exp_tag.delete();
    #3;
    checkOutput("reset_midfill_outputs", 192'(all_out), 192'(0));
    wc = write_count;
    waitDrain("reset_midfill");
    checkOutput("reset_midfill_no_late_writes", 192'(write_count), 192'(wc));
    checkOutput("reset_midfill_no_tag", 192'(tag_cyc), 192'(-1));

    // Back-to-back misses.
    $display("[TB] back-to-back misses");
    lat = int'($urandom_range(5, 1)); max_gap = 2;
    applyStimulus(16'h0123, 1'b0);
    waitTag("b2b_first");
    t1 = tag_cyc;
    applyStimulus(16'h3210, 1'b0);
    waitTag("b2b_second");
    checkOutput("b2b_second_fill_start", 192'(first_read_cyc - t1), 192'(2));
    @(negedge clk);
    #3;
    checkOutput("b2b_busy_after_tag", 192'(fsm_busy), 192'(0));
    waitDrain("b2b");

    // Random fills.
    $display("[TB] random fills");
    for (int i = 0; i < 10; i++) begin
      lat     = int'($urandom_range(6, 1));
      max_gap = int'($urandom_range(3, 1));
      applyStimulus(16'($urandom), 1'b0);
      finishFill("random");
      checkOutput("random_write_count", 192'(write_count), 192'(8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
